// File: rtl/mac4_pkg.sv
// Shared definitions for the 4-bit MAC: frame FSM states and default datapath widths.
package mac4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int ACC_W_DEF = 8;
    localparam int LEN_W_DEF = 4;

endpackage

// File: rtl/mac4_accumulator.sv
// Accumulation and frame-control stage of the 4-bit MAC: closes the loop through an
// external combinational adder and hands each frame result downstream via valid/ready.
module mac4_accumulator
    import mac4_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    input  logic [ACC_W-1:0] in_prod,
    output logic             in_ready,
    output logic [ACC_W-1:0] add_a,
    output logic [ACC_W-1:0] add_b,
    output logic             add_cin,
    input  logic [ACC_W-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    // Once a carry escapes, saturation pins the result to all-ones for the rest of the frame.
    function automatic logic [ACC_W-1:0] next_acc(input logic [ACC_W-1:0] sum,
                                                  input logic cout);
        if (SAT != 0 && cout)
            return {ACC_W{1'b1}};
        return sum;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (cfg_len == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cfg_len;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = next_acc(add_s, add_cout);
                    ovf_d = ovf_q | add_cout;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign add_a     = in_prod;
    assign add_b     = acc_q;
    assign add_cin   = 1'b0;

endmodule

// File: tb/tb_mac4_accumulator.sv
// Directed bench for mac4_accumulator: wrap and saturate instances share stimulus and are
// checked every cycle against an arithmetic frame model plus literal frame results.
module tb_mac4_accumulator;

    localparam int ACC_W = 8;
    localparam int LEN_W = 4;
    localparam int ACC_MAX = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             in_valid = 1'b0;
    logic [ACC_W-1:0] in_prod = '0;
    logic             out_ready = 1'b0;

    logic             rdy0, ov0, busy0, cin0, ovf0, cout0;
    logic [ACC_W-1:0] a0, b0, s0, acc0;
    logic             rdy1, ov1, busy1, cin1, ovf1, cout1;
    logic [ACC_W-1:0] a1, b1, s1, acc1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-ins for the sibling Brent-Kung adder
    assign {cout0, s0} = {1'b0, a0} + {1'b0, b0} + {8'd0, cin0};
    assign {cout1, s1} = {1'b0, a1} + {1'b0, b1} + {8'd0, cin1};

    mac4_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_prod(in_prod), .in_ready(rdy0),
        .add_a(a0), .add_b(b0), .add_cin(cin0), .add_s(s0), .add_cout(cout0),
        .out_valid(ov0), .out_acc(acc0), .out_ovf(ovf0), .out_ready(out_ready),
        .busy(busy0)
    );

    mac4_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_prod(in_prod), .in_ready(rdy1),
        .add_a(a1), .add_b(b1), .add_cin(cin1), .add_s(s1), .add_cout(cout1),
        .out_valid(ov1), .out_acc(acc1), .out_ovf(ovf1), .out_ready(out_ready),
        .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: phase 0 idle, 1 collecting, 2 result pending
    int m_phase = 0, m_rem = 0;
    int m_acc0 = 0, m_acc1 = 0;
    logic m_ovf0 = 1'b0, m_ovf1 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_rem <= 0;
            m_acc0 <= 0; m_acc1 <= 0;
            m_ovf0 <= 1'b0; m_ovf1 <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_acc0 <= 0; m_acc1 <= 0;
                    m_ovf0 <= 1'b0; m_ovf1 <= 1'b0;
                    if (cfg_len == 0) m_phase <= 2;
                    else begin m_rem <= int'(cfg_len); m_phase <= 1; end
                end
                1: if (in_valid) begin
                    m_acc0 <= (m_acc0 + int'(in_prod)) % (ACC_MAX + 1);
                    m_ovf0 <= m_ovf0 | (m_acc0 + int'(in_prod) > ACC_MAX);
                    m_acc1 <= (m_acc1 + int'(in_prod) > ACC_MAX) ? ACC_MAX : m_acc1 + int'(in_prod);
                    m_ovf1 <= m_ovf1 | (m_acc1 + int'(in_prod) > ACC_MAX);
                    m_rem  <= m_rem - 1;
                    if (m_rem == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("w_in_ready", rdy0, m_phase == 1);
            chk("w_out_valid", ov0, m_phase == 2);
            chk("w_busy", busy0, m_phase != 0);
            chk("w_add_b", b0, m_acc0);
            chk("w_add_a", a0, in_prod);
            chk("w_add_cin", cin0, 0);
            chk("s_in_ready", rdy1, m_phase == 1);
            chk("s_out_valid", ov1, m_phase == 2);
            chk("s_busy", busy1, m_phase != 0);
            chk("s_add_b", b1, m_acc1);
            chk("s_add_a", a1, in_prod);
            chk("s_add_cin", cin1, 0);
            if (m_phase == 2) begin
                chk("w_out_acc", acc0, m_acc0);
                chk("w_out_ovf", ovf0, m_ovf0);
                chk("s_out_acc", acc1, m_acc1);
                chk("s_out_ovf", ovf1, m_ovf1);
            end
        end
    end

    // Apply one cycle of inputs; returns one cycle later, just after the falling edge.
    task automatic drive(input logic st, input int len, input logic v, input int p,
                         input logic ordy);
        start = st; cfg_len = LEN_W'(len); in_valid = v; in_prod = ACC_W'(p);
        out_ready = ordy;
        @(negedge clk); #1;
    endtask

    task automatic expect_result(input int e0, input logic f0, input int e1, input logic f1);
        chk("res_valid_w", ov0, 1);
        chk("res_valid_s", ov1, 1);
        chk("res_acc_w", acc0, e0);
        chk("res_ovf_w", ovf0, f0);
        chk("res_acc_s", acc1, e1);
        chk("res_ovf_s", ovf1, f1);
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, {rdy0, rdy1}, 0);
        chk({tag, "_valid"}, {ov0, ov1}, 0);
        chk({tag, "_acc"}, {acc0, acc1}, 0);
        chk({tag, "_ovf"}, {ovf0, ovf1}, 0);
        chk({tag, "_busy"}, {busy0, busy1}, 0);
        chk({tag, "_addb"}, {b0, b1}, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk); #1;
        chk_zero("reset");
        @(negedge clk); #1 rst = 1'b0;

        drive(1, 3, 0, 0, 0);
        chk("start_to_ready", rdy0, 1);
        drive(0, 0, 1, 10, 0);
        drive(0, 0, 1, 20, 0);
        drive(0, 0, 1, 30, 0);
        expect_result(60, 0, 60, 0);

        drive(1, 2, 0, 0, 0);
        drive(0, 0, 1, 200, 0);
        drive(0, 0, 1, 100, 0);
        expect_result(44, 1, 255, 1);

        drive(1, 3, 0, 0, 0);
        drive(0, 0, 1, 200, 0);
        drive(0, 0, 1, 100, 0);
        drive(0, 0, 1, 5, 0);
        expect_result(49, 1, 255, 1);

        drive(1, 2, 0, 0, 0);
        drive(0, 0, 1, 225, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 225, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_acc", acc0, 194);
            chk("bp_rdy", rdy0, 0);
            drive(0, 0, 0, 0, 0);
        end
        expect_result(194, 1, 255, 1);

        drive(1, 0, 0, 0, 0);
        expect_result(0, 0, 0, 0);

        drive(1, 3, 0, 0, 0);
        drive(0, 0, 1, 1, 0);
        drive(1, 7, 0, 0, 0);
        drive(0, 0, 1, 2, 0);
        chk("ign_start_pending", ov0, 0);
        drive(0, 0, 1, 3, 0);
        expect_result(6, 0, 6, 0);

        drive(1, 3, 0, 0, 0);
        drive(0, 0, 1, 50, 0);
        chk("pre_rst_addb", b0, 50);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk); #1 rst = 1'b0;
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 1, 7, 0);
        expect_result(7, 0, 7, 0);
        drive(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mac4_accumulator.md
# mac4_accumulator

Accumulation and frame-control stage of the 4-bit MAC. It sits directly downstream of the 8-bit Brent-Kung adder and closes the MAC loop:
- it presents each incoming 4x4 product and the current accumulator to the adder;
- it registers the adder's sum and carry-out;
- it counts products per frame;
- it hands the final result downstream over a valid/ready handshake.

## Interface
Parameters:
- ACC_W, 8: accumulator/adder width; must equal the adder width.
- LEN_W, 4: width of the frame-length field; a frame holds at most 2^LEN_W − 1 products.
- SAT, 0: overflow policy. 0 = wrap modulo 2^ACC_W. 1 = saturate to all-ones.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a frame; sampled only in IDLE.
- cfg_len  in  LEN_W  number of products in the frame; sampled with start.
- in_valid  in  1  product available.
- in_prod  in  ACC_W  product from the 4x4 multiplier stage.
- in_ready  out  1  block can accept a product.
- add_a  out  ACC_W  adder operand a; equal to in_prod, combinational.
- add_b  out  ACC_W  adder operand b; equal to the acc register.
- add_cin  out  1  tied 0.
- add_s  in  ACC_W  adder sum.
- add_cout  in  1  adder carry-out.
- out_valid  out  1  frame result available.
- out_acc  out  ACC_W  frame result.
- out_ovf  out  1  sticky: at least one accepted add in the frame produced carry-out.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: in_ready=0, out_valid=0.
    - start=1 and cfg_len≠0: acc←0, ovf←0, cnt←cfg_len, go to ACCUM.
    - start=1 and cfg_len=0: acc←0, ovf←0, go directly to DONE (empty frame, result 0).
  - ACCUM: in_ready=1.
    - Each cycle with in_valid=1 is an accept. On accept:
      - SAT=0: acc←add_s.
      - SAT=1: acc←add_cout ? all-ones : add_s.
      - ovf←ovf|add_cout.
      - cnt←cnt−1.
    - An accept with cnt=1 moves the FSM to DONE.
  - DONE: in_ready=0, out_valid=1, out_acc=acc, out_ovf=ovf.
    - With out_ready=1, return to IDLE.
    - out_acc and out_ovf stay stable while out_valid=1 and out_ready=0.
- start outside IDLE is ignored. cfg_len is ignored except when start is sampled.
- in_prod is unconstrained. The full ACC_W-bit value is added: 4x4 products never exceed 225, but the block does not check this.
- The adder is combinational. The path in_prod → add_a → adder → add_s → acc is a single cycle.

## Timing
- Reset values: in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0, add_b=0; state IDLE, cnt=0.
- Reset asserted mid-frame discards the frame immediately, asynchronously; the next action is a fresh start after release.
- start sampled in cycle t → in_ready=1 in cycle t+1.
- Accept in cycle t → updated acc is visible on add_b in t+1. Back-to-back accepts sustain 1 product/cycle.
- Last accept in cycle t → out_valid=1 in t+1.
- Minimum out_valid-to-start spacing: one cycle in IDLE. out_valid=1 with out_ready=1 in cycle t → IDLE in t+1, and start is accepted in t+1.
- Saturation is sticky within the frame. Once acc is all-ones and a further add carries, acc stays all-ones.

## Structure
- Shared package mac4_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - the ACC_W and LEN_W defaults, also used by the MAC top and the multiplier stage.
- There is no sub-module. The Brent-Kung adder is a sibling instance in the MAC top, wired through the add_* ports. The block itself holds only the FSM, counter, acc and ovf registers, and the saturation mux.

## Test plan
- Wrap: SAT=0, cfg_len=3, products 10, 20, 30 back-to-back → out_acc=60, out_ovf=0, out_valid 1 cycle after the third accept.
- Overflow wrap: SAT=0, cfg_len=2, products 200, 100 → out_acc=44, out_ovf=1.
- Saturate: SAT=1, cfg_len=3, products 200, 100, 5 → out_acc=255, out_ovf=1.
- Backpressure and gaps:
  - cfg_len=2 with in_valid toggling 1,0,0,1, products 225, 225 → out_acc=194, ovf=1.
  - out_ready held 0 for 5 cycles → out_acc stable and in_ready=0 throughout.
- Empty and ignored start: start with cfg_len=0 → out_valid next cycle with out_acc=0, out_ovf=0; a start pulsed during ACCUM leaves cnt unchanged.
- Reset mid-frame: rst asserted after 1 of 3 accepts → all outputs 0 immediately. A new frame with cfg_len=1 and product 7 then yields out_acc=7.
